operand_pack_fifo: RTL and testbench

- Parametrised, clocked successor to the ALU's combinational operand packer.
- Each accepted transfer concatenates two WIDTH-bit operands into one 2*WIDTH-bit word and stores it in a DEPTH-entry FIFO.
- Words are presented to the ALU datapath through a valid/ready handshake.
- Adds an operand-order (swap) mode, occupancy count, synchronous flush and a sticky overflow flag.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/fifo_ptr_ctrl.sv | 68 ++++++
 rtl/operand_pack_fifo.sv | 97 +++++++++
 tb/tb_operand_pack_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU operand-packing constants and helper function.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic PACK_NORMAL = 1'b0;
  localparam logic PACK_SWAP   = 1'b1;
  localparam int   PACK_MAX_W  = 32;

  // a is the low operand in normal order; w is the live operand width.
  function automatic logic [2*PACK_MAX_W-1:0] pack_operands(
    input logic [PACK_MAX_W-1:0] a,
    input logic [PACK_MAX_W-1:0] b,
    input logic                  swap,
    input int unsigned           w
  );
    logic [2*PACK_MAX_W-1:0] ea;
    logic [2*PACK_MAX_W-1:0] eb;
    ea = {{PACK_MAX_W{1'b0}}, a};
    eb = {{PACK_MAX_W{1'b0}}, b};
    if (swap == PACK_SWAP) begin
      pack_operands = (ea << w) | eb;
    end else begin
      pack_operands = (eb << w) | ea;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_ctrl
// Brief    : Read/write pointers, occupancy count and full/empty for the FIFO.
// Revision : 1.0  initial release
// ============================================================================
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic          flush,
  output logic          push_ok,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] wr_ptr,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop_ok;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    next_ptr = (p == c_last) ? '0 : p + AW'(1);
  endfunction

  // Occupancy alone separates full from empty when the pointers coincide.
  assign full     = (r_count == c_full);
  assign empty    = (r_count == '0);
  assign push_ok  = push_req & ~full & ~flush;
  assign w_pop_ok = pop_req & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_ok)  r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop_ok) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_ptr = r_rd_ptr;
  assign wr_ptr = r_wr_ptr;
  assign count  = r_count;

endmodule
`default_nettype wire

// File: rtl/operand_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : operand_pack_fifo
// Brief    : Packs operand pairs into 2*WIDTH words and queues them in a FIFO.
// Revision : 1.0  initial release
// ============================================================================
module operand_pack_fifo
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic               swap,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [CW-1:0]      count,
  output logic               overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*WIDTH-1:0]      r_mem [DEPTH];
  logic                    r_overflow;
  logic [PACK_MAX_W-1:0]   w_op_a;
  logic [PACK_MAX_W-1:0]   w_op_b;
  logic [2*PACK_MAX_W-1:0] w_pack_full;
  logic [2*WIDTH-1:0]      w_word;
  logic                    w_push_ok;
  logic                    w_full;
  logic                    w_empty;
  logic [AW-1:0]           w_rd_ptr;
  logic [AW-1:0]           w_wr_ptr;

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    w_op_a[WIDTH-1:0] = in0;
    w_op_b[WIDTH-1:0] = in1;
  end

  assign w_pack_full = pack_operands(w_op_a, w_op_b, swap, WIDTH);
  assign w_word      = w_pack_full[2*WIDTH-1:0];

  generate
    if (WIDTH < PACK_MAX_W) begin : g_trim
      logic w_unused_hi;
      assign w_unused_hi = ^w_pack_full[2*PACK_MAX_W-1:2*WIDTH];
    end
  endgenerate

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (in_valid),
    .pop_req  (out_ready),
    .flush    (flush),
    .push_ok  (w_push_ok),
    .full     (w_full),
    .empty    (w_empty),
    .rd_ptr   (w_rd_ptr),
    .wr_ptr   (w_wr_ptr),
    .count    (count)
  );

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[w_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out       = w_empty ? '0 : r_mem[w_rd_ptr];
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_operand_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_pack_fifo
// Brief    : Self-checking bench: vector table, corner sequences, random+model.
// Revision : 1.0  initial release
// ============================================================================
module tb_operand_pack_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in0, in1;
  logic       swap, in_valid, out_ready, flush;
  logic       in_ready, out_valid, overflow;
  logic [7:0] out;
  logic [2:0] count;

  int n_pass  = 0;
  int n_total = 0;

  operand_pack_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in1       (in1),
    .swap      (swap),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] i1;
    logic [3:0] i0;
    logic       sw;
    logic       ordy;
    logic       fl;
    logic [7:0] e_out;
    logic       e_v;
    logic       e_r;
    logic [2:0] e_c;
    logic       e_o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input logic [3:0] i1, input logic [3:0] i0,
                              input logic sw, input logic ordy, input logic fl,
                              input logic [7:0] e_out, input logic e_v, input logic e_r,
                              input logic [2:0] e_c, input logic e_o);
    vec_t v;
    v.iv = iv; v.i1 = i1; v.i0 = i0; v.sw = sw; v.ordy = ordy; v.fl = fl;
    v.e_out = e_out; v.e_v = e_v; v.e_r = e_r; v.e_c = e_c; v.e_o = e_o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_v,
                         input logic e_r, input logic [2:0] e_c, input logic e_o);
    chk({tag, ".out"},       32'(out),       32'(e_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(e_r));
    chk({tag, ".count"},     32'(count),     32'(e_c));
    chk({tag, ".overflow"},  32'(overflow),  32'(e_o));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; swap = 1'b0;
    in0 = 4'h0; in1 = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wgen(input int k);
    logic [3:0] lo;
    lo = 4'(k);
    return {lo, ~lo};
  endfunction

  logic [7:0] mq[$];
  logic       mov;
  logic [7:0] word, exp_out;
  bit         m_push, m_pop;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_all("reset", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);

    // iv i1 i0 sw ordy fl | out v r c o
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 4'hA, 4'h3, 0, 0, 0, 8'hA3, 1, 1, 3'd1, 0));
    tbl.push_back(mk(1, 4'hA, 4'h3, 1, 0, 0, 8'hA3, 1, 1, 3'd2, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h3A, 1, 1, 3'd1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h00, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 0, 8'h11, 1, 1, 3'd1, 0));
    tbl.push_back(mk(1, 4'h2, 4'h2, 0, 0, 0, 8'h11, 1, 1, 3'd2, 0));
    tbl.push_back(mk(1, 4'h3, 4'h3, 0, 0, 0, 8'h11, 1, 1, 3'd3, 0));
    tbl.push_back(mk(1, 4'h4, 4'h4, 0, 0, 0, 8'h11, 1, 0, 3'd4, 0));
    tbl.push_back(mk(1, 4'h5, 4'h5, 0, 0, 0, 8'h11, 1, 0, 3'd4, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h22, 1, 1, 3'd3, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h33, 1, 1, 3'd2, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h44, 1, 1, 3'd1, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h00, 0, 1, 3'd0, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 1, 8'h00, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 4'h5, 4'h5, 0, 0, 0, 8'h55, 1, 1, 3'd1, 0));
    tbl.push_back(mk(1, 4'h6, 4'h6, 0, 0, 0, 8'h55, 1, 1, 3'd2, 0));
    tbl.push_back(mk(1, 4'h7, 4'h7, 0, 0, 0, 8'h55, 1, 1, 3'd3, 0));
    tbl.push_back(mk(1, 4'h8, 4'h8, 0, 0, 0, 8'h55, 1, 0, 3'd4, 0));
    // full with simultaneous push and pop: pop happens, push dropped
    tbl.push_back(mk(1, 4'h9, 4'h9, 0, 1, 0, 8'h66, 1, 1, 3'd3, 1));
    // flush beats a concurrent push and clears overflow
    tbl.push_back(mk(1, 4'hC, 4'hC, 0, 1, 1, 8'h00, 0, 1, 3'd0, 0));

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in1 = tbl[i].i1; in0 = tbl[i].i0;
      swap = tbl[i].sw; out_ready = tbl[i].ordy; flush = tbl[i].fl;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_v, tbl[i].e_r,
              tbl[i].e_c, tbl[i].e_o);
    end
    idle_inputs();

    // Streaming at constant occupancy 2; pointers wrap several times.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; {in1, in0} = wgen(k);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; {in1, in0} = wgen(i + 2);
      tick();
      chk_all($sformatf("stream%0d", i), wgen(i + 1), 1'b1, 1'b1, 3'd2, 1'b0);
    end
    idle_inputs();

    // Asynchronous reset between edges empties the FIFO immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.count",     32'(count),     32'd0);
    chk("async_rst.out",       32'(out),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("post_rst", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);

    // Randomised traffic against a queue-based reference.
    mq.delete();
    mov = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in0       = 4'($urandom);
      in1       = 4'($urandom);
      swap      = 1'($urandom);
      out_ready = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      exp_out = (mq.size() > 0) ? mq[0] : 8'h00;
      chk_all($sformatf("rand%0d", i), exp_out, mq.size() > 0, mq.size() < DEPTH,
              3'(mq.size()), mov);
      word = swap ? {in0, in1} : {in1, in0};
      if (flush) begin
        mq.delete();
        mov = 1'b0;
      end else begin
        if (in_valid && mq.size() == DEPTH) mov = 1'b1;
        m_push = in_valid && (mq.size() < DEPTH);
        m_pop  = out_ready && (mq.size() > 0);
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back(word);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
